ad7606_sample_streamer: RTL and testbench

- Downstream of the AD7606 serial-to-parallel capture stage.
- Captures each completed 128-bit conversion result (8 channels x 16 bit, channel 1 in bits [127:112]) when the capture stage raises rd_en.
- Buffers results in a small FIFO and emits them as a valid/ready stream of 32-bit tagged words, one channel per word, with frame marking for the DMA/processing path.
- Runs in the 12.5 MHz clkin domain; a result arrives roughly every 121 cycles.

---
 rtl/ad7606_sample_streamer.sv | 169 ++++++++++++++++
 tb/tb_ad7606_sample_streamer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad7606_sample_streamer.sv
// Buffers AD7606 128-bit conversion results in a small FIFO and re-emits them
// as a 32-bit valid/ready stream, one tagged channel word per beat, with frame marking.
module ad7606_sample_streamer #(
    parameter int FIFO_AW   = 2,
    parameter int FRAME_LEN = 2048
) (
    input  logic         clkin,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         rd_en,
    input  logic [127:0] din,
    output logic [31:0]  m_tdata,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic         m_tlast,
    output logic         overflow,
    input  logic         clear_ovf,
    output logic [15:0]  frame_cnt
);

    localparam int               DEPTH    = 1 << FIFO_AW;
    localparam logic [15:0]      LAST_IDX = 16'(FRAME_LEN - 1);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    logic                 rd_en_q;
    logic [128:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q;
    logic [FIFO_AW-1:0]   rd_ptr_q;
    logic [FIFO_AW:0]     count_q;
    logic [FIFO_AW:0]     count_d;
    logic [15:0]          idx_q;
    logic [15:0]          idx_d;
    logic [15:0]          frame_q;
    logic [15:0]          frame_d;
    logic                 ovf_q;
    logic                 ovf_d;
    state_t               state_q;
    state_t               state_d;
    logic [127:0]         shreg_q;
    logic [127:0]         shreg_d;
    logic                 last_q;
    logic                 last_d;
    logic [2:0]           ch_q;
    logic [2:0]           ch_d;

    logic                 cap;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 drop;
    logic                 pop;
    logic                 last_flag;
    logic [128:0]         head;

    // Full is judged on the registered occupancy, so a pop on the same edge cannot rescue a write.
    assign cap        = rd_en & ~rd_en_q & enable;
    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign push       = cap & ~fifo_full;
    assign drop       = cap & fifo_full;
    assign last_flag  = (idx_q == LAST_IDX);
    assign head       = mem_q[rd_ptr_q];

    assign m_tvalid  = (state_q == STREAM);
    assign m_tlast   = (state_q == STREAM) & last_q & (ch_q == 3'd7);
    assign m_tdata   = {13'd0, ch_q, shreg_q[127:112]};
    assign overflow  = ovf_q;
    assign frame_cnt = frame_q;

    always_comb begin
        idx_d   = idx_q;
        frame_d = frame_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        if (clear_ovf) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
        if (!enable) begin
            idx_d = 16'd0;
        end else if (push) begin
            idx_d = last_flag ? 16'd0 : idx_q + 16'd1;
            if (last_flag) begin
                frame_d = frame_q + 16'd1;
            end
        end
        if (push && !pop) begin
            count_d = count_q + (FIFO_AW + 1)'(1);
        end else if (!push && pop) begin
            count_d = count_q - (FIFO_AW + 1)'(1);
        end
    end

    // The last word of an entry may pull the next entry straight in, avoiding a bubble.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        last_d  = last_q;
        ch_d    = ch_q;
        pop     = 1'b0;
        if (state_q == IDLE) begin
            if (!fifo_empty) begin
                pop     = 1'b1;
                shreg_d = head[127:0];
                last_d  = head[128];
                ch_d    = 3'd0;
                state_d = STREAM;
            end
        end else if (m_tready) begin
            if (ch_q != 3'd7) begin
                shreg_d = {shreg_q[111:0], 16'h0000};
                ch_d    = ch_q + 3'd1;
            end else if (!fifo_empty) begin
                pop     = 1'b1;
                shreg_d = head[127:0];
                last_d  = head[128];
                ch_d    = 3'd0;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            idx_q    <= 16'd0;
            frame_q  <= 16'd0;
            ovf_q    <= 1'b0;
            state_q  <= IDLE;
            shreg_q  <= '0;
            last_q   <= 1'b0;
            ch_q     <= 3'd0;
        end else begin
            rd_en_q  <= rd_en;
            count_q  <= count_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            last_q   <= last_d;
            ch_q     <= ch_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            end
        end
    end

    always_ff @(posedge clkin) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {last_flag, din};
        end
    end

endmodule

// File: tb/tb_ad7606_sample_streamer.sv
// Bench for ad7606_sample_streamer: directed scenarios plus random traffic against
// a word-queue reference model of the tagged channel stream.
module tb_ad7606_sample_streamer;

    localparam int FRAME_LEN = 4;

    logic         clkin     = 1'b0;
    logic         rst_n     = 1'b0;
    logic         enable    = 1'b0;
    logic         rd_en     = 1'b0;
    logic         m_tready  = 1'b0;
    logic         clear_ovf = 1'b0;
    logic [127:0] din       = '0;
    logic [31:0]  m_tdata;
    logic         m_tvalid;
    logic         m_tlast;
    logic         overflow;
    logic [15:0]  frame_cnt;

    int           total     = 0;
    int           bad       = 0;
    int           wordCount = 0;
    logic [32:0]  expQ[$];
    int           modelIdx    = 0;
    logic [15:0]  modelFrames = 16'd0;
    bit           randReady   = 1'b0;
    logic         prevStall   = 1'b0;

    ad7606_sample_streamer #(
        .FIFO_AW   (2),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clkin     (clkin),
        .rst_n     (rst_n),
        .enable    (enable),
        .rd_en     (rd_en),
        .din       (din),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .overflow  (overflow),
        .clear_ovf (clear_ovf),
        .frame_cnt (frame_cnt)
    );

    always #5 clkin = ~clkin;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
        if (randReady) m_tready = ($urandom_range(0, 3) != 0);
    endtask

    // One accepted conversion becomes eight words, channel 1 first.
    task automatic pushModel(input logic [127:0] d);
        logic        isLast;
        logic [15:0] s;
        logic [2:0]  c3;
        isLast = (modelIdx == FRAME_LEN - 1);
        for (int c = 0; c < 8; c++) begin
            s  = d[127 - 16 * c -: 16];
            c3 = 3'(c);
            expQ.push_back({isLast && (c == 7), 13'd0, c3, s});
        end
        if (isLast) begin
            modelIdx = 0;
            modelFrames++;
        end else begin
            modelIdx++;
        end
    endtask

    task automatic applyStimulus(input logic [127:0] d, input bit accepted);
        din   = d;
        rd_en = 1'b1;
        tick();
        if (enable && accepted) pushModel(d);
        rd_en = 1'b0;
        tick();
    endtask

    task automatic setEnable(input logic v);
        enable = v;
        if (!v) modelIdx = 0;
        tick();
    endtask

    task automatic waitDrain(input string tag, input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, expQ.size(), 0);
        tick();
        checkOutput({tag, "_idle"}, {31'd0, m_tvalid}, 0);
    endtask

    task automatic waitQueueBelow(input int limit);
        int n = 0;
        while (expQ.size() > limit && n < 500) begin
            tick();
            n++;
        end
        checkOutput("queue_room", {31'd0, expQ.size() > limit}, 0);
    endtask

    function automatic logic [127:0] randWord();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Every valid beat must show the head of the expected queue; a handshake retires it.
    always @(negedge clkin) begin
        if (rst_n) begin
            if (prevStall) checkOutput("hold_valid", {31'd0, m_tvalid}, 1);
            if (m_tvalid) begin
                total++;
                assert (expQ.size() != 0) else begin
                    bad++;
                    $error("[TB] FAIL extra_word observed=0x%08h expected=none", m_tdata);
                end
                if (expQ.size() != 0) begin
                    checkOutput("tdata", m_tdata, expQ[0][31:0]);
                    checkOutput("tlast", {31'd0, m_tlast}, {31'd0, expQ[0][32]});
                    if (m_tready) begin
                        void'(expQ.pop_front());
                        wordCount++;
                    end
                end
            end
            prevStall = m_tvalid && !m_tready;
        end else begin
            prevStall = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          w0;
        int          n;
        logic [15:0] fb;
        logic [127:0] seqWord;
        seqWord = 128'h0001_0002_0003_0004_0005_0006_0007_0008;

        repeat (3) tick();
        checkOutput("rst_valid", {31'd0, m_tvalid}, 0);
        checkOutput("rst_last", {31'd0, m_tlast}, 0);
        checkOutput("rst_data", m_tdata, 0);
        checkOutput("rst_ovf", {31'd0, overflow}, 0);
        checkOutput("rst_frames", {16'd0, frame_cnt}, 0);
        rst_n    = 1'b1;
        enable   = 1'b1;
        m_tready = 1'b1;
        tick();

        $display("[TB] single capture with held rd_en");
        w0    = wordCount;
        din   = seqWord;
        rd_en = 1'b1;
        tick();
        pushModel(seqWord);
        checkOutput("lat_k_valid", {31'd0, m_tvalid}, 0);
        tick();
        checkOutput("lat_k1_valid", {31'd0, m_tvalid}, 1);
        checkOutput("lat_k1_data", m_tdata, 32'h0000_0001);
        repeat (48) tick();
        rd_en = 1'b0;
        tick();
        checkOutput("single_words", wordCount - w0, 8);
        checkOutput("single_idle", {31'd0, m_tvalid}, 0);

        $display("[TB] backpressure at channel 3");
        w0 = wordCount;
        applyStimulus(seqWord, 1'b1);
        n = 0;
        while (!(m_tvalid && m_tdata == 32'h0003_0004) && n < 20) begin
            tick();
            n++;
        end
        checkOutput("bp_reach", m_tdata, 32'h0003_0004);
        m_tready = 1'b0;
        repeat (5) begin
            tick();
            checkOutput("bp_hold_data", m_tdata, 32'h0003_0004);
            checkOutput("bp_hold_valid", {31'd0, m_tvalid}, 1);
        end
        m_tready = 1'b1;
        waitDrain("bp_drain", 50);
        checkOutput("bp_words", wordCount - w0, 8);

        $display("[TB] framing with 9 captures");
        setEnable(1'b0);
        setEnable(1'b1);
        fb = modelFrames;
        for (int i = 0; i < 9; i++) begin
            waitQueueBelow(24);
            applyStimulus(randWord(), 1'b1);
        end
        waitDrain("frame_drain", 200);
        checkOutput("frame_cnt_2", {16'd0, frame_cnt}, {16'd0, fb + 16'd2});

        $display("[TB] overflow with stalled stream");
        w0       = wordCount;
        m_tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(randWord(), i < 5);
            if (i == 4) checkOutput("ovf_before", {31'd0, overflow}, 0);
        end
        checkOutput("ovf_set", {31'd0, overflow}, 1);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        checkOutput("ovf_clear", {31'd0, overflow}, 0);
        m_tready = 1'b1;
        waitDrain("ovf_drain", 200);
        checkOutput("ovf_words", wordCount - w0, 40);
        checkOutput("ovf_frames", {16'd0, frame_cnt}, {16'd0, modelFrames});

        $display("[TB] enable gating and index restart");
        setEnable(1'b0);
        applyStimulus(randWord(), 1'b1);
        applyStimulus(randWord(), 1'b1);
        repeat (10) tick();
        checkOutput("en_off_valid", {31'd0, m_tvalid}, 0);
        checkOutput("en_off_queue", expQ.size(), 0);
        setEnable(1'b1);
        fb = modelFrames;
        applyStimulus(randWord(), 1'b1);
        applyStimulus(randWord(), 1'b1);
        setEnable(1'b0);
        setEnable(1'b1);
        for (int i = 0; i < 4; i++) begin
            waitQueueBelow(24);
            applyStimulus(randWord(), 1'b1);
        end
        waitDrain("en_drain", 200);
        checkOutput("en_frames", {16'd0, frame_cnt}, {16'd0, fb + 16'd1});

        $display("[TB] random traffic with random ready");
        randReady = 1'b1;
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 10)) tick();
            waitQueueBelow(24);
            applyStimulus(randWord(), 1'b1);
        end
        randReady = 1'b0;
        m_tready  = 1'b1;
        waitDrain("rand_drain", 400);
        checkOutput("rand_frames", {16'd0, frame_cnt}, {16'd0, modelFrames});

        $display("[TB] reset in the middle of a sample");
        m_tready = 1'b0;
        for (int i = 0; i < 6; i++) applyStimulus(randWord(), i < 5);
        checkOutput("rst_pre_ovf", {31'd0, overflow}, 1);
        m_tready = 1'b1;
        n = 0;
        while (!(m_tvalid && m_tdata[18:16] == 3'd5) && n < 20) begin
            tick();
            n++;
        end
        checkOutput("rst_reach_ch5", {29'd0, m_tdata[18:16]}, 5);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_valid", {31'd0, m_tvalid}, 0);
        checkOutput("rst_mid_ovf", {31'd0, overflow}, 0);
        checkOutput("rst_mid_data", m_tdata, 0);
        checkOutput("rst_mid_frames", {16'd0, frame_cnt}, 0);
        expQ.delete();
        modelIdx    = 0;
        modelFrames = 16'd0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        w0 = wordCount;
        applyStimulus(seqWord, 1'b1);
        waitDrain("post_rst_drain", 50);
        checkOutput("post_rst_words", wordCount - w0, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
